// File: rtl/mixer_dsp_pkg.sv
// rtl/mixer_dsp_pkg.sv - shared types and helpers for the mixer DSP blocks
package mixer_dsp_pkg;

    localparam int PCM_W = 24;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } filt_state_t;

    // Window exponents above the history depth collapse onto the full history.
    function automatic int clamp_log2(input int win, input int max_log2);
        return (win > max_log2) ? max_log2 : win;
    endfunction

endpackage

// File: rtl/sample_history_ring.sv
// rtl/sample_history_ring.sv - sample history storage, one write port, one async read port
module sample_history_ring
    import mixer_dsp_pkg::*;
#(
    parameter int DATA_W     = PCM_W,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [LOG2_DEPTH-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [LOG2_DEPTH-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    // Storage is deliberately unreset; the owner flushes it with a write sweep.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/moving_average_filter.sv
// rtl/moving_average_filter.sv - run-time windowed boxcar filter on signed PCM samples
module moving_average_filter
    import mixer_dsp_pkg::*;
#(
    parameter int DATA_W        = PCM_W,
    parameter int LOG2_MAX_TAPS = 4,
    parameter int WIN_W         = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              on,
    input  logic [WIN_W-1:0]  win_log2,
    input  logic              clear,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    localparam int MAX_TAPS = 1 << LOG2_MAX_TAPS;
    localparam int SUM_W    = DATA_W + LOG2_MAX_TAPS;

    filt_state_t state, state_next;

    logic [LOG2_MAX_TAPS-1:0] wr_ptr;
    logic [LOG2_MAX_TAPS-1:0] clr_ptr;
    logic [LOG2_MAX_TAPS-1:0] rd_addr;
    logic [WIN_W-1:0]         win_reg;
    logic [WIN_W-1:0]         win_clamped;

    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [SUM_W-1:0]  x_ext;
    logic signed [SUM_W-1:0]  x_old_ext;
    logic [DATA_W-1:0]        x_old;
    logic [DATA_W-1:0]        avg;

    logic                     accept;
    logic                     clear_done;

    logic                     ring_we;
    logic [LOG2_MAX_TAPS-1:0] ring_addr;
    logic [DATA_W-1:0]        ring_wdata;

    assign win_clamped = WIN_W'(clamp_log2(int'(win_log2), LOG2_MAX_TAPS));

    assign in_ready   = (state == RUN);
    assign accept     = in_valid && in_ready;
    assign clear_done = (state == CLEAR) && (clr_ptr == LOG2_MAX_TAPS'(MAX_TAPS - 1));

    // The sample leaving the window sits 2**win_reg slots behind the write
    // pointer; a full-depth window wraps onto wr_ptr itself (oldest entry).
    assign rd_addr = wr_ptr - LOG2_MAX_TAPS'(32'd1 << win_reg);

    assign x_ext     = SUM_W'($signed(in_data));
    assign x_old_ext = SUM_W'($signed(x_old));
    assign sum_next  = sum + x_ext - x_old_ext;
    assign avg       = DATA_W'(sum_next >>> win_reg);

    sample_history_ring #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_MAX_TAPS)
    ) u_history (
        .clk     (clk),
        .wr_en   (ring_we),
        .wr_addr (ring_addr),
        .wr_data (ring_wdata),
        .rd_addr (rd_addr),
        .rd_data (x_old)
    );

    always_comb begin
        ring_we    = 1'b0;
        ring_addr  = wr_ptr;
        ring_wdata = in_data;
        if (state == CLEAR) begin
            ring_we    = 1'b1;
            ring_addr  = clr_ptr;
            ring_wdata = '0;
        end else if (accept) begin
            ring_we = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR) begin
            if (clear_done) begin
                state_next = RUN;
            end
        end else if (clear || (win_clamped != win_reg)) begin
            state_next = CLEAR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            sum       <= '0;
            wr_ptr    <= '0;
            clr_ptr   <= '0;
            win_reg   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_next;
            out_valid <= accept;
            out_data  <= accept ? (on ? avg : in_data) : '0;

            // History and sum track every accepted sample, bypassed or not.
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (clear_done) begin
                    sum    <= '0;
                    wr_ptr <= '0;
                end
            end else if (accept) begin
                sum    <= sum_next;
                wr_ptr <= wr_ptr + 1'b1;
            end

            if ((state == RUN) && (state_next == CLEAR)) begin
                win_reg <= win_clamped;
            end
        end
    end

endmodule
